up_down_counter: RTL
====================

UP_DOWN_COUNTER -- requirements
Module: up_down_counter

Interface
REQ-001 The block SHALL have parameter COUNT_WIDTH, default 3: width of the count register.
REQ-002 The block SHALL have parameter MAX_COUNT, default 2**COUNT_WIDTH-1: terminal value. Legal range 1..2**COUNT_WIDTH-1.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = modulo wrap, 1 = hold at bound.
REQ-004 clk  input  1  The block's one clock; all state updates on its rising edge.
REQ-005 rst  input  1  Reset, asynchronous, active-low.
REQ-006 en  input  1  Count enable.
REQ-007 up  input  1  Direction: 1 = increment, 0 = decrement; sampled only when en=1.
REQ-008 clear  input  1  Synchronous clear to 0.
REQ-009 load  input  1  Synchronous load of load_value.
REQ-010 load_value  input  COUNT_WIDTH  Value to load.
REQ-011 count  output  COUNT_WIDTH  Registered count value.
REQ-012 tc  output  1  Registered one-cycle terminal-count pulse.
REQ-013 at_max  output  1  Combinational: count == MAX_COUNT.
REQ-014 at_min  output  1  Combinational: count == 0.

Function
REQ-015 Per-edge priority SHALL be: clear > load > en > hold.
REQ-016 clear=1 SHALL set count to 0 on the next edge, ignoring load, en and up; tc SHALL be 0 that edge.
REQ-017 load=1 with clear=0 SHALL set count to min(load_value, MAX_COUNT) on the next edge; tc SHALL be 0 that edge.
REQ-018 en=1, up=1, count<MAX_COUNT SHALL increment count by 1 with 1-cycle latency.
REQ-019 en=1, up=0, count>0 SHALL decrement count by 1 with 1-cycle latency.
REQ-020 SATURATE=0, en=1, up=1, count==MAX_COUNT SHALL wrap count to 0 and set tc=1 for exactly that next cycle.
REQ-021 SATURATE=0, en=1, up=0, count==0 SHALL wrap count to MAX_COUNT and set tc=1 for exactly that next cycle.
REQ-022 SATURATE=1 at a bound moving outward SHALL hold count; tc SHALL pulse 1 on the first blocked edge only and SHALL stay 0 while it remains blocked.
REQ-023 A saturated counter SHALL leave the bound when enabled in the opposite direction, with no tc.
REQ-024 en=0 with clear=0 and load=0 SHALL hold count; tc SHALL be 0.
REQ-025 tc SHALL never be 1 for two consecutive cycles unless two successive wrap events occur (SATURATE=0, MAX_COUNT=1 case).
REQ-026 Arithmetic SHALL be evaluated modulo MAX_COUNT+1, never modulo 2**COUNT_WIDTH when MAX_COUNT < 2**COUNT_WIDTH-1.
REQ-027 count SHALL never exceed MAX_COUNT after any edge.
REQ-028 A direction change SHALL take effect on the edge at which it is sampled, with no dead cycle.

Reset
REQ-029 rst=0 SHALL force count=0 and tc=0 immediately, independent of clk.
REQ-030 The saturate-blocked tracking state SHALL reset to not-blocked.
REQ-031 While rst=0 all inputs SHALL be ignored.
REQ-032 After rst deasserts, the first edge with en=1 SHALL act on count=0.
REQ-033 Reset asserted mid-count SHALL discard the in-flight value with no tc.

Verification (COUNT_WIDTH=3, MAX_COUNT=5 unless stated)
REQ-034 SATURATE=0, en=1, up=1 from reset for 7 edges -> count 1,2,3,4,5,0,1; tc=1 only in the cycle count=0; at_max=1 when count=5.
REQ-035 SATURATE=0, up=0 from count=0 -> count 5,4,...; tc=1 in the cycle count=5; at_min=1 when count=0.
REQ-036 SATURATE=1, up=1 for 8 edges -> count stops at 5; tc=1 for one cycle only; then up=0 one edge -> count=4, tc=0.
REQ-037 Priority: clear=1, load=1, load_value=3, en=1 -> count=0; next edge clear=0, load=1, load_value=7 -> count=5 (clamped); tc=0 in both cycles.
REQ-038 Counting at count=3, assert rst between clock edges -> count=0 and tc=0 before the next edge; after deassert, en=1, up=1 -> count=1.
REQ-039 MAX_COUNT=7, SATURATE=0: increment from 7 -> count=0 with tc=1; decrement from 0 -> 7 with tc=1.

Source files
------------

// File: rtl/up_down_counter.sv
// Up/down counter with a configurable terminal value, selectable wrap or
// saturate behaviour, synchronous clear/load and a one-cycle terminal-count
// pulse. count and tc are registered; at_max/at_min decode the live count.
module up_down_counter #(
    parameter int COUNT_WIDTH = 3,
    parameter int MAX_COUNT   = 2**COUNT_WIDTH - 1,
    parameter int SATURATE    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   up,
    input  logic                   clear,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   tc,
    output logic                   at_max,
    output logic                   at_min
);

    localparam logic [COUNT_WIDTH-1:0] MAX_VAL = COUNT_WIDTH'(MAX_COUNT);
    localparam logic [COUNT_WIDTH-1:0] ZERO    = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] count_r;
    logic                   tc_r;
    // Set while a saturating counter sits at a bound and keeps being pushed
    // outward; it suppresses repeat tc pulses until the counter moves again.
    logic                   blocked_r;

    logic [COUNT_WIDTH-1:0] next_count_s;
    logic                   next_tc_s;
    logic                   next_blocked_s;

    // Next-state decode with priority clear > load > enabled count > hold.
    always_comb begin
        next_count_s   = count_r;
        next_tc_s      = 1'b0;
        next_blocked_s = blocked_r;
        if (clear) begin
            next_count_s   = ZERO;
            next_blocked_s = 1'b0;
        end else if (load) begin
            next_count_s   = (load_value > MAX_VAL) ? MAX_VAL : load_value;
            next_blocked_s = 1'b0;
        end else if (en) begin
            if (up) begin
                if (count_r < MAX_VAL) begin
                    next_count_s   = count_r + ONE;
                    next_blocked_s = 1'b0;
                end else if (SATURATE == 0) begin
                    // Wrap modulo MAX_COUNT+1, not modulo 2**COUNT_WIDTH.
                    next_count_s   = ZERO;
                    next_tc_s      = 1'b1;
                    next_blocked_s = 1'b0;
                end else begin
                    next_count_s   = count_r;
                    next_tc_s      = ~blocked_r;
                    next_blocked_s = 1'b1;
                end
            end else begin
                if (count_r > ZERO) begin
                    next_count_s   = count_r - ONE;
                    next_blocked_s = 1'b0;
                end else if (SATURATE == 0) begin
                    next_count_s   = MAX_VAL;
                    next_tc_s      = 1'b1;
                    next_blocked_s = 1'b0;
                end else begin
                    next_count_s   = count_r;
                    next_tc_s      = ~blocked_r;
                    next_blocked_s = 1'b1;
                end
            end
        end else begin
            next_count_s   = count_r;
            next_tc_s      = 1'b0;
            next_blocked_s = blocked_r;
        end
    end

    // State registers; reset clears count, tc and the blocked tracking at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r   <= ZERO;
            tc_r      <= 1'b0;
            blocked_r <= 1'b0;
        end else begin
            count_r   <= next_count_s;
            tc_r      <= next_tc_s;
            blocked_r <= next_blocked_s;
        end
    end

    assign count  = count_r;
    assign tc     = tc_r;
    assign at_max = (count_r == MAX_VAL);
    assign at_min = (count_r == ZERO);

endmodule
